riscv_instr_injector: RTL and testbench

Parametrised instruction-source unit between the core's fetch stage and instruction memory, replacing the single-word external-instruction path with a buffered injection queue. A verification agent or debug master pushes instructions into a DEPTH-entry FIFO with a valid/ready handshake. The core's fetch stage pops one entry per fetch request when the unit is in an external mode. A one-shot mode drains the queue and then hands fetch back to memory automatically; underflow, occupancy and an issued-instruction count are reported for monitors and scoreboards.

---
 rtl/riscv_instr_injector.sv | 138 +++++++++++++
 tb/tb_riscv_instr_injector.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_instr_injector.sv
// Instruction source for the fetch stage: memory, or a DEPTH-entry injection queue.
// The one-shot mode drains the queue and then returns fetch to memory.
module riscv_instr_injector #(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned DEPTH     = 8,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013,
    parameter int unsigned CNT_W     = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [1:0]                 mode_i,
    input  logic                       flush_i,
    input  logic                       inj_valid_i,
    input  logic [XLEN-1:0]            inj_instr_i,
    output logic                       inj_ready_o,
    input  logic                       fetch_req_i,
    input  logic [XLEN-1:0]            imem_instr_i,
    output logic [XLEN-1:0]            instr_o,
    output logic                       instr_src_o,
    output logic [$clog2(DEPTH):0]     level_o,
    output logic                       underflow_o,
    output logic [CNT_W-1:0]           issued_cnt_o,
    output logic                       oneshot_done_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;

    typedef enum logic [1:0] {
        S_MEM,
        S_EXT,
        S_ONESHOT,
        S_DONE
    } state_t;

    state_t            state;
    state_t            state_d;
    logic [XLEN-1:0]   mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [LVL_W-1:0]  level;
    logic [CNT_W-1:0]  issued_cnt;
    logic              underflow;
    logic              src_q;
    logic              done_q;

    logic              empty;
    logic              push;
    logic              pop;
    logic              underflow_ev;
    logic              last_pop;

    assign empty        = (level == '0);
    assign inj_ready_o  = reset && (level < LVL_W'(DEPTH)) && !flush_i;
    assign push         = inj_valid_i && inj_ready_o;
    assign pop          = src_q && fetch_req_i && !empty && !flush_i;
    assign underflow_ev = src_q && fetch_req_i && empty;
    // A push in the same cycle keeps the queue non-empty, so the drain is not finished.
    assign last_pop     = pop && (level == LVL_W'(1)) && !push;

    always_comb begin
        state_d = S_MEM;
        unique case (mode_i)
            2'd1: state_d = S_EXT;
            2'd2: begin
                unique case (state)
                    S_MEM, S_EXT: state_d = S_ONESHOT;
                    S_ONESHOT:    state_d = last_pop ? S_DONE : S_ONESHOT;
                    S_DONE:       state_d = S_DONE;
                    default:      state_d = S_MEM;
                endcase
            end
            default: state_d = S_MEM;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= S_MEM;
            src_q      <= 1'b0;
            done_q     <= 1'b0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level      <= '0;
            issued_cnt <= '0;
            underflow  <= 1'b0;
        end else begin
            state  <= state_d;
            src_q  <= (state_d == S_EXT) || (state_d == S_ONESHOT);
            done_q <= (state_d == S_DONE);

            if (underflow_ev) begin
                underflow <= 1'b1;
            end
            if (pop) begin
                issued_cnt <= issued_cnt + CNT_W'(1);
            end

            if (flush_i) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                level  <= '0;
            end else begin
                if (push) begin
                    wr_ptr <= wr_ptr + PTR_W'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + PTR_W'(1);
                end
                unique case ({push, pop})
                    2'b10:   level <= level + LVL_W'(1);
                    2'b01:   level <= level - LVL_W'(1);
                    default: level <= level;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= inj_instr_i;
        end
    end

    always_comb begin
        instr_o = imem_instr_i;
        if (src_q) begin
            instr_o = empty ? XLEN'(NOP_INSTR) : mem[rd_ptr];
        end
    end

    assign instr_src_o    = src_q;
    assign level_o        = level;
    assign underflow_o    = underflow;
    assign issued_cnt_o   = issued_cnt;
    assign oneshot_done_o = done_q;

endmodule

// File: tb/tb_riscv_instr_injector.sv
// Scoreboard bench for riscv_instr_injector: fetch expectations are queued by the
// stimulus and checked by an independent monitor; status outputs are checked directly.
module tb_riscv_instr_injector;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned CNT_W = 16;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic              clk = 1'b0;
    logic              reset;
    logic [1:0]        mode;
    logic              flush;
    logic              inj_valid;
    logic [XLEN-1:0]   inj_instr;
    logic              inj_ready;
    logic              fetch_req;
    logic [XLEN-1:0]   imem_instr;
    logic [XLEN-1:0]   instr;
    logic              instr_src;
    logic [3:0]        level;
    logic              underflow;
    logic [CNT_W-1:0]  issued_cnt;
    logic              oneshot_done;

    typedef struct {
        logic [31:0] instr;
        logic        src;
        int          tag;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_cmp = 0;
    int   n_err = 0;
    int   tag_n = 0;

    always #5 clk = ~clk;

    riscv_instr_injector #(
        .XLEN      (XLEN),
        .DEPTH     (DEPTH),
        .NOP_INSTR (NOP),
        .CNT_W     (CNT_W)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .mode_i         (mode),
        .flush_i        (flush),
        .inj_valid_i    (inj_valid),
        .inj_instr_i    (inj_instr),
        .inj_ready_o    (inj_ready),
        .fetch_req_i    (fetch_req),
        .imem_instr_i   (imem_instr),
        .instr_o        (instr),
        .instr_src_o    (instr_src),
        .level_o        (level),
        .underflow_o    (underflow),
        .issued_cnt_o   (issued_cnt),
        .oneshot_done_o (oneshot_done)
    );

    always @(negedge clk) begin
        if (reset && fetch_req) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL fetch_unexpected: got instr %h src %b, required no fetch", instr, instr_src);
            end else begin
                mon_e = exp_q.pop_front();
                if (instr !== mon_e.instr || instr_src !== mon_e.src) begin
                    n_err++;
                    $display("FAIL fetch_%0d: got instr %h src %b, required instr %h src %b",
                             mon_e.tag, instr, instr_src, mon_e.instr, mon_e.src);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_fetch(input logic [31:0] w, input logic s);
        exp_q.push_back('{instr: w, src: s, tag: tag_n});
        tag_n++;
    endtask

    task automatic push_w(input logic [31:0] w);
        inj_valid = 1'b1;
        inj_instr = w;
        tick();
        inj_valid = 1'b0;
    endtask

    task automatic fetch(input logic [31:0] w, input logic s);
        fetch_req = 1'b1;
        expect_fetch(w, s);
        tick();
        fetch_req = 1'b0;
    endtask

    task automatic status(input string tag, input int lvl, input int cnt, input logic uf);
        @(negedge clk);
        check({tag, "_level"}, 32'(level), 32'(lvl));
        check({tag, "_cnt"}, 32'(issued_cnt), 32'(cnt));
        check({tag, "_underflow"}, 32'(underflow), 32'(uf));
        tick();
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached, required normal completion");
        $fatal(1, "timeout");
    end

    initial begin
        reset      = 1'b1;
        mode       = 2'd0;
        flush      = 1'b0;
        inj_valid  = 1'b0;
        inj_instr  = '0;
        fetch_req  = 1'b0;
        imem_instr = 32'hCAFE_0001;
        #2 reset = 1'b0;

        // Reset values
        @(negedge clk);
        check("rst_level", 32'(level), 32'd0);
        check("rst_cnt", 32'(issued_cnt), 32'd0);
        check("rst_underflow", 32'(underflow), 32'd0);
        check("rst_ready", 32'(inj_ready), 32'd0);
        check("rst_src", 32'(instr_src), 32'd0);
        check("rst_done", 32'(oneshot_done), 32'd0);
        check("rst_instr", instr, 32'hCAFE_0001);
        tick();
        reset = 1'b1;

        // External mode: three pushes then three fetches in order
        mode = 2'd1;
        push_w(32'h0050_0093);
        push_w(32'h00A0_0113);
        push_w(32'h0020_81B3);
        fetch(32'h0050_0093, 1'b1);
        fetch(32'h00A0_0113, 1'b1);
        fetch(32'h0020_81B3, 1'b1);
        status("ext3", 0, 3, 1'b0);

        // Fill to DEPTH, then refused push alongside a pop
        for (int i = 0; i < 8; i++) push_w(32'h1000_0000 + 32'(i));
        @(negedge clk);
        check("full_level", 32'(level), 32'd8);
        check("full_ready", 32'(inj_ready), 32'd0);
        tick();
        inj_valid = 1'b1;
        inj_instr = 32'h1000_00FF;
        fetch_req = 1'b1;
        expect_fetch(32'h1000_0000, 1'b1);
        tick();
        inj_valid = 1'b0;
        fetch_req = 1'b0;
        status("full_pop", 7, 4, 1'b0);
        for (int i = 1; i < 8; i++) fetch(32'h1000_0000 + 32'(i), 1'b1);

        // Underflow on empty queue, sticky
        fetch(NOP, 1'b1);
        status("uflow", 0, 11, 1'b1);
        repeat (10) tick();
        status("uflow_hold", 0, 11, 1'b1);

        // One-shot drain from memory mode
        mode = 2'd0;
        tick();
        push_w(32'hAAAA_0001);
        push_w(32'hAAAA_0002);
        mode = 2'd2;
        fetch(32'hCAFE_0001, 1'b0);
        fetch(32'hAAAA_0001, 1'b1);
        fetch_req = 1'b1;
        expect_fetch(32'hAAAA_0002, 1'b1);
        @(negedge clk);
        check("os_last_done", 32'(oneshot_done), 32'd0);
        tick();
        expect_fetch(32'hCAFE_0001, 1'b0);
        @(negedge clk);
        check("os_done", 32'(oneshot_done), 32'd1);
        check("os_src", 32'(instr_src), 32'd0);
        check("os_instr", instr, 32'hCAFE_0001);
        tick();
        fetch_req = 1'b0;
        repeat (2) tick();
        @(negedge clk);
        check("os_hold", 32'(oneshot_done), 32'd1);
        tick();
        status("os_end", 0, 13, 1'b1);

        // Flush overrides push and pop
        mode = 2'd1;
        tick();
        for (int i = 0; i < 4; i++) push_w(32'hF000_0000 + 32'(i));
        flush     = 1'b1;
        inj_valid = 1'b1;
        inj_instr = 32'hF000_00FF;
        fetch_req = 1'b1;
        expect_fetch(32'hF000_0000, 1'b1);
        @(negedge clk);
        check("flush_ready", 32'(inj_ready), 32'd0);
        tick();
        flush     = 1'b0;
        inj_valid = 1'b0;
        fetch_req = 1'b0;
        @(negedge clk);
        check("flush_src", 32'(instr_src), 32'd1);
        check("flush_done", 32'(oneshot_done), 32'd0);
        tick();
        status("flush", 0, 13, 1'b1);

        // Mid-operation reset with queued entries
        for (int i = 0; i < 5; i++) push_w(32'hE000_0000 + 32'(i));
        @(negedge clk);
        check("pre_rst_level", 32'(level), 32'd5);
        tick();
        reset      = 1'b0;
        imem_instr = 32'hBEEF_0002;
        #1;
        check("mid_rst_level", 32'(level), 32'd0);
        check("mid_rst_cnt", 32'(issued_cnt), 32'd0);
        check("mid_rst_underflow", 32'(underflow), 32'd0);
        check("mid_rst_ready", 32'(inj_ready), 32'd0);
        check("mid_rst_src", 32'(instr_src), 32'd0);
        check("mid_rst_instr", instr, 32'hBEEF_0002);
        tick();
        reset = 1'b1;
        tick();
        fetch(NOP, 1'b1);
        status("post_rst", 0, 0, 1'b1);

        // Simultaneous push and pop keeps level and order
        push_w(32'hC000_0000);
        push_w(32'hC000_0001);
        inj_valid = 1'b1;
        inj_instr = 32'hC000_0002;
        fetch_req = 1'b1;
        expect_fetch(32'hC000_0000, 1'b1);
        tick();
        inj_valid = 1'b0;
        fetch_req = 1'b0;
        status("pushpop", 2, 1, 1'b1);
        fetch(32'hC000_0001, 1'b1);
        fetch(32'hC000_0002, 1'b1);
        status("pushpop_end", 0, 3, 1'b1);

        // Push into empty queue is not bypassed
        inj_valid = 1'b1;
        inj_instr = 32'hD000_0001;
        fetch_req = 1'b1;
        expect_fetch(NOP, 1'b1);
        tick();
        inj_valid = 1'b0;
        fetch_req = 1'b0;
        status("nobypass", 1, 3, 1'b1);
        fetch(32'hD000_0001, 1'b1);
        status("nobypass_end", 0, 4, 1'b1);

        repeat (2) tick();
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL fetch_pending: got %0d unchecked fetches, required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
